// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
// Shared types for the RV32I pipeline MEM stage:
//   mem_state_t      - data-cache handshake FSM states (IDLE/BUSY/DONE)
//   load_funct3_t    - funct3 encodings of the load instructions
//   store_funct3_t   - funct3 encodings of the store instructions
//   rv32i_ctrl_word  - per-instruction control bits carried down the pipe
//   rv32i_stage_reg  - full stage-register contents (EX/MEM, MEM/WB)
// Helper: store_mask() builds the byte-enable mask of a store.
// -----------------------------------------------------------------------------
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef struct packed {
        logic        dcache_read;
        logic        dcache_write;
        logic [2:0]  funct3;
        logic        load_regfile;
        logic [4:0]  rd;
    } rv32i_ctrl_word;

    typedef struct packed {
        rv32i_ctrl_word control_word;
        logic [31:0]    pc;
        logic [31:0]    alu_out;
        logic [31:0]    rs2_out;
        logic [31:0]    mdr_out;
    } rv32i_stage_reg;

    // Byte-enable mask of a store; halfwords and words are aligned down.
    function automatic logic [3:0] store_mask(input logic [2:0] funct3,
                                              input logic [1:0] off);
        logic [3:0] mask;
        case (funct3)
            sb:      mask = 4'b0001 << off;
            sh:      mask = 4'b0011 << {off[1], 1'b0};
            sw:      mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Purely combinational load lane select and extension.
// Ports:
//   funct3     in  load funct3 (lb/lh/lw/lbu/lhu)
//   off        in  byte offset within the word (alu_out[1:0])
//   rdata      in  full word read from the data cache
//   load_value out selected byte/halfword/word, sign- or zero-extended
// Misaligned halfwords/words are aligned down (off[0] / off ignored).
// -----------------------------------------------------------------------------
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] load_value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select by offset, then extension by load type.
    always_comb begin
        case (off)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (off[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            lb:      load_value = {{24{byte_s[7]}}, byte_s};
            lbu:     load_value = {24'h000000, byte_s};
            lh:      load_value = {{16{half_s[15]}}, half_s};
            lhu:     load_value = {16'h0000, half_s};
            lw:      load_value = rdata;
            default: load_value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// RV32I MEM pipeline stage: data-cache handshake FSM, store lane/mask
// generation, load extraction and MEM/WB word assembly.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ex_mem_word        EX/MEM stage-register contents
//   advance            MEM/WB stage register loads this cycle
//   dcache_rdata/resp  cache read data and single-cycle completion pulse
//   mem_wb_word        next MEM/WB contents (combinational)
//   dcache_read/write  request strobes
//   dcache_address     word address; dcache_wdata write data; dcache_mbe mask
//   mem_stall          high while this stage holds the pipeline
//   perf_access_cnt    completed accesses  (counting with MEM_PERF_CNT_EN)
//   perf_stall_cnt     mem_stall cycles    (counting with MEM_PERF_CNT_EN)
// Build option: define MEM_PERF_CNT_EN to implement the performance
// counters; otherwise both perf ports read 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module mem_stage
    import rv32i_types::*;
(
    input  logic           clk,
    input  logic           rst,
    input  rv32i_stage_reg ex_mem_word,
    input  logic           advance,
    input  logic [31:0]    dcache_rdata,
    input  logic           dcache_resp,
    output rv32i_stage_reg mem_wb_word,
    output logic           dcache_read,
    output logic           dcache_write,
    output logic [31:0]    dcache_address,
    output logic [31:0]    dcache_wdata,
    output logic [3:0]     dcache_mbe,
    output logic           mem_stall,
    output logic [31:0]    perf_access_cnt,
    output logic [31:0]    perf_stall_cnt
);

    rv32i_ctrl_word cw_s;
    mem_state_t     state_r;
    logic [31:0]    hold_r;
    logic [31:0]    load_value_s;
    logic [1:0]     off_s;
    logic           req_s;
    logic           active_s;
    logic           complete_s;

    assign cw_s  = ex_mem_word.control_word;
    assign off_s = ex_mem_word.alu_out[1:0];
    assign req_s = cw_s.dcache_read | cw_s.dcache_write;

    mem_align u_align (
        .funct3     (cw_s.funct3),
        .off        (off_s),
        .rdata      (dcache_rdata),
        .load_value (load_value_s)
    );

    // Handshake status: DONE has finished its access and must not re-issue.
    always_comb begin
        active_s   = (state_r != DONE);
        complete_s = active_s & req_s & dcache_resp;
        mem_stall  = active_s & req_s & ~dcache_resp;
    end

    // Cache request: strobes, address, store data replication and mask.
    always_comb begin
        dcache_read    = active_s & cw_s.dcache_read;
        dcache_write   = active_s & cw_s.dcache_write;
        dcache_address = {ex_mem_word.alu_out[31:2], 2'b00};
        case (cw_s.funct3)
            sb:      dcache_wdata = {4{ex_mem_word.rs2_out[7:0]}};
            sh:      dcache_wdata = {2{ex_mem_word.rs2_out[15:0]}};
            sw:      dcache_wdata = ex_mem_word.rs2_out;
            default: dcache_wdata = ex_mem_word.rs2_out;
        endcase
        if (cw_s.dcache_write) begin
            dcache_mbe = store_mask(cw_s.funct3, off_s);
        end else if (cw_s.dcache_read) begin
            dcache_mbe = 4'b1111;
        end else begin
            dcache_mbe = 4'b0000;
        end
    end

    // MEM/WB word: pass-through with the load result substituted.
    always_comb begin
        mem_wb_word = ex_mem_word;
        if (!cw_s.dcache_read) begin
            mem_wb_word.mdr_out = 32'h0000_0000;
        end else if (state_r == DONE) begin
            mem_wb_word.mdr_out = hold_r;
        end else begin
            mem_wb_word.mdr_out = load_value_s;
        end
    end

    // Handshake FSM and load hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            hold_r  <= 32'h0000_0000;
        end else begin
            if (complete_s && cw_s.dcache_read) begin
                hold_r <= load_value_s;
            end
            case (state_r)
                IDLE: begin
                    if (req_s && dcache_resp) begin
                        state_r <= advance ? IDLE : DONE;
                    end else if (req_s) begin
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (dcache_resp) begin
                        state_r <= advance ? IDLE : DONE;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                DONE: begin
                    if (advance) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [31:0] access_cnt_r;
    logic [31:0] stall_cnt_r;

    // Performance counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            access_cnt_r <= 32'h0000_0000;
            stall_cnt_r  <= 32'h0000_0000;
        end else begin
            if (complete_s) begin
                access_cnt_r <= access_cnt_r + 32'd1;
            end
            if (mem_stall) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign perf_access_cnt = access_cnt_r;
    assign perf_stall_cnt  = stall_cnt_r;
`else
    assign perf_access_cnt = 32'h0000_0000;
    assign perf_stall_cnt  = 32'h0000_0000;
`endif

endmodule
